// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the Y86-style sequential stage controller:
//   state_e      - controller state encoding (also driven out on 'stage')
//   STAT_*       - Y86 status codes reported on 'stat'
//   ICODE_*      - instruction codes the controller needs to recognise
// No ports; imported by seq_next_pc and seq_stage_ctrl.
// ----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_PCUPD     = 3'd6,
        ST_HALT      = 3'd7
    } state_e;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_HALT = 4'd0;
    localparam logic [3:0] ICODE_JXX  = 4'd7;
    localparam logic [3:0] ICODE_CALL = 4'd8;
    localparam logic [3:0] ICODE_RET  = 4'd9;

endpackage

// File: rtl/seq_next_pc.sv
// ----------------------------------------------------------------------------
// seq_next_pc
// Purely combinational next-PC selection used in the PC-update stage.
// Ports:
//   icode_i   [3:0]      instruction code of the retiring instruction
//   cnd_i                execute condition flag (taken jump)
//   valC_i    [ADDR_W]   constant word (jump / call target)
//   valP_i    [ADDR_W]   fall-through address
//   valM_i    [ADDR_W]   value read from memory (return address)
//   nextPc_o  [ADDR_W]   selected next program counter
// ----------------------------------------------------------------------------
module seq_next_pc
    import seq_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [3:0]        icode_i,
    input  logic              cnd_i,
    input  logic [ADDR_W-1:0] valC_i,
    input  logic [ADDR_W-1:0] valP_i,
    input  logic [ADDR_W-1:0] valM_i,
    output logic [ADDR_W-1:0] nextPc_o
);

    // Taken jumps and calls go to the constant target, returns to the popped
    // address, everything else (including not-taken jumps) falls through.
    always_comb begin
        nextPc_o = valP_i;
        if ((icode_i == ICODE_JXX && cnd_i) || icode_i == ICODE_CALL) begin
            nextPc_o = valC_i;
        end else if (icode_i == ICODE_RET) begin
            nextPc_o = valM_i;
        end
    end

endmodule

// File: rtl/seq_stage_ctrl.sv
// ----------------------------------------------------------------------------
// seq_stage_ctrl
// Sequential (non-pipelined) Y86 stage controller. Walks each instruction
// through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, raising one
// stage strobe per stage, tracking the PC, the status code and a saturating
// retired-instruction counter. Faults and halts park the machine in HALT
// until reset.
//
// Optional feature: define SEQ_WDOG_EN to enable the retired-instruction
// watchdog (halts with HLT and raises wdog_trip when the WDOG_LIMIT-th
// instruction retires). Without it wdog_trip is tied low.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      leave IDLE and begin at current pc
//   icode, instr_valid         fetch results
//   imem_error, dmem_error     instruction / data memory faults
//   cnd                        execute condition flag
//   valC, valP, valM           next-PC candidates
//   pc                         registered program counter
//   fetch_en .. wb_en          one-hot stage strobes
//   stage                      current state encoding
//   stat                       Y86 status (AOK/HLT/ADR/INS)
//   retired                    instructions completed since reset
//   wdog_trip                  watchdog fired
// ----------------------------------------------------------------------------
module seq_stage_ctrl
    import seq_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter int                CNT_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                WDOG_LIMIT = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic              instr_valid,
    input  logic              imem_error,
    input  logic              dmem_error,
    input  logic              cnd,
    input  logic [ADDR_W-1:0] valC,
    input  logic [ADDR_W-1:0] valP,
    input  logic [ADDR_W-1:0] valM,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_en,
    output logic              decode_en,
    output logic              exec_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic [2:0]        stage,
    output logic [2:0]        stat,
    output logic [CNT_W-1:0]  retired,
    output logic              wdog_trip
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        stat_q, stat_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [ADDR_W-1:0] nextPc;

    seq_next_pc #(
        .ADDR_W (ADDR_W)
    ) uNextPc (
        .icode_i  (icode),
        .cnd_i    (cnd),
        .valC_i   (valC),
        .valP_i   (valP),
        .valM_i   (valM),
        .nextPc_o (nextPc)
    );

`ifdef SEQ_WDOG_EN
    localparam logic [CNT_W:0] WDOG_LIMIT_EXT = (CNT_W+1)'(WDOG_LIMIT);

    logic wdogTrip_q, wdogTrip_d;
    logic wdogHit;

    // Compared one bit wider so a saturated counter never aliases to zero.
    assign wdogHit   = (({1'b0, retired_q} + 1'b1) == WDOG_LIMIT_EXT);
    assign wdog_trip = wdogTrip_q;
`else
    assign wdog_trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            stat_q    <= STAT_AOK;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
        end
    end

`ifdef SEQ_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdogTrip_q <= 1'b0;
        end else begin
            wdogTrip_q <= wdogTrip_d;
        end
    end
`endif

    // Next-state logic. pc and retired only ever move in PCUPD, so a fault
    // anywhere else leaves pc pointing at the offending instruction.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stat_d     = stat_q;
        retired_d  = retired_q;
`ifdef SEQ_WDOG_EN
        wdogTrip_d = wdogTrip_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_error) begin
                    state_d = ST_HALT;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_d = ST_HALT;
                    stat_d  = STAT_INS;
                end else if (icode == ICODE_HALT) begin
                    state_d = ST_HALT;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d = ST_MEMORY;
            end
            ST_MEMORY: begin
                if (dmem_error) begin
                    state_d = ST_HALT;
                    stat_d  = STAT_ADR;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                state_d = ST_PCUPD;
            end
            ST_PCUPD: begin
                pc_d    = nextPc;
                state_d = ST_FETCH;
                if (retired_q != '1) begin
                    retired_d = retired_q + 1'b1;
                end
`ifdef SEQ_WDOG_EN
                if (wdogHit) begin
                    state_d    = ST_HALT;
                    stat_d     = STAT_HLT;
                    wdogTrip_d = 1'b1;
                end
`endif
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register so they drop the
    // moment reset is asserted.
    always_comb begin
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        unique case (state_q)
            ST_FETCH:     fetch_en  = 1'b1;
            ST_DECODE:    decode_en = 1'b1;
            ST_EXECUTE:   exec_en   = 1'b1;
            ST_MEMORY:    mem_en    = 1'b1;
            ST_WRITEBACK: wb_en     = 1'b1;
            default: ;
        endcase
    end

    assign pc      = pc_q;
    assign stage   = state_q;
    assign stat    = stat_q;
    assign retired = retired_q;

endmodule

// File: doc/seq_stage_ctrl.md
SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

Interface
REQ-001 Parameter ADDR_W, default 64: PC and address-operand width.
REQ-002 Parameter CNT_W, default 32: retired-instruction counter width.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Parameter WDOG_LIMIT, default 1000: retired-instruction limit (used only under SEQ_WDOG_EN).
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 rst_n  in  1  reset; one clock; asynchronous, active-low.
REQ-007 start  in  1  leave IDLE and begin execution at current PC.
REQ-008 icode  in  4  instruction code from fetch.
REQ-009 instr_valid  in  1  fetch decoded a legal instruction.
REQ-010 imem_error  in  1  fetch address fault.
REQ-011 dmem_error  in  1  data memory fault.
REQ-012 cnd  in  1  execute condition flag.
REQ-013 valC, valP, valM  in  ADDR_W each  constant, fall-through, memory-read values.
REQ-014 pc  out  ADDR_W  registered program counter.
REQ-015 fetch_en, decode_en, exec_en, mem_en, wb_en  out  1 each  one-hot stage strobes.
REQ-016 stage  out  3  current state encoding.
REQ-017 stat  out  3  Y86 status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-018 retired  out  CNT_W  instructions completed since reset.
REQ-019 wdog_trip  out  1  watchdog fired.

Function
REQ-020 States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT; exactly one stage strobe is high in each of FETCH..WRITEBACK, none in IDLE, PCUPD, HALT.
REQ-021 IDLE->FETCH on start=1; start is ignored in every other state.
REQ-022 Normal sequence FETCH->DECODE->EXECUTE->MEMORY->WRITEBACK->PCUPD->FETCH; 6 cycles per instruction.
REQ-023 In FETCH: imem_error=1 -> HALT with stat=ADR; else instr_valid=0 -> HALT with stat=INS; else icode=0 -> HALT with stat=HLT; priority in that order.
REQ-024 In MEMORY: dmem_error=1 -> HALT with stat=ADR; no writeback strobe issued.
REQ-025 In PCUPD: pc <= valC if icode=7 and cnd=1; valC if icode=8; valM if icode=9; valP otherwise.
REQ-026 pc changes only in PCUPD; on any fault or halt, pc holds the faulting/halt instruction address.
REQ-027 retired increments by 1 in each PCUPD; saturates at all-ones, no wrap.
REQ-028 HALT is absorbing until reset; stat holds its fault code, strobes low.
REQ-029 stat=AOK in all states except HALT.
REQ-030 pc is ADDR_W-bit, taken verbatim from inputs; wrap past all-ones is the fetch unit's concern.

Reset
REQ-031 rst_n low asserts immediately, any state: state=IDLE, pc=RESET_PC, stat=AOK, retired=0, wdog_trip=0, all strobes 0.
REQ-032 First posedge with rst_n high stays in IDLE unless start=1.

Configuration
REQ-033 Macro SEQ_WDOG_EN defined: in PCUPD, if retired+1 equals WDOG_LIMIT, go to HALT with stat=HLT and wdog_trip=1 (pc updated normally first).
REQ-034 SEQ_WDOG_EN undefined: no watchdog logic; wdog_trip tied 0; WDOG_LIMIT unused.

Structure
REQ-035 Shared package seq_pkg holds state enum, stat codes (AOK/HLT/ADR/INS) and icode constants (HALT=0, JXX=7, CALL=8, RET=9).
REQ-036 One sub-module seq_next_pc: combinational next-PC select per REQ-025.

Verification
REQ-037 Reset, start=1, icode=6 valid, valP=0x0A -> strobes cycle FETCH..WRITEBACK, after PCUPD pc=0x0A, retired=1.
REQ-038 icode=7, cnd=1, valC=0x40 -> pc=0x40; repeat with cnd=0, valP=0x49 -> pc=0x49.
REQ-039 icode=9, valM=0x100 -> pc=0x100; icode=8, valC=0x20 -> pc=0x20.
REQ-040 icode=0 in FETCH at pc=0x30 -> HALT, stat=2, pc=0x30, retired unchanged; start ignored afterwards.
REQ-041 instr_valid=0 -> stat=4; imem_error=1 and instr_valid=0 together -> stat=3; dmem_error in MEMORY -> stat=3, wb_en never asserted.
REQ-042 rst_n dropped mid-EXECUTE -> same-cycle IDLE, pc=RESET_PC; with SEQ_WDOG_EN, WDOG_LIMIT=3 -> wdog_trip=1 after 3rd PCUPD.
